// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester side and the FIFO write side of fifo_wr_arbiter.
//
// Signals:
//   req       requester -> arbiter  per-requester request, held while a word waits
//   req_data  requester -> arbiter  packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full FIFO      -> arbiter  FIFO full flag
//   gnt       arbiter   -> requester one-hot accept strobe
//   wr        arbiter   -> FIFO     write strobe
//   wr_data   arbiter   -> FIFO     write word (zero when wr=0)
//   owner     arbiter   -> observer current / most recent burst owner
//   busy      arbiter   -> observer high while a burst is in progress
//
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          wr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [OWN_W-1:0]              owner;
  logic                          busy;

  modport slave (
    input  req,
    input  req_data,
    input  fifo_full,
    output gnt,
    output wr,
    output wr_data,
    output owner,
    output busy
  );

  modport master (
    output req,
    output req_data,
    output fifo_full,
    input  gnt,
    input  wr,
    input  wr_data,
    input  owner,
    input  busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one FIFO write port between NUM_REQ requesters. Arbitration is
// round-robin; the winner keeps the port for up to MAX_BURST accepted words.
// A write is never issued while the FIFO reports full.
//
// Ports:
//   clk    input   single clock
//   rst_n  input   synchronous, active-low reset
//   bus    slave   fifo_wr_arbiter_if: req, req_data, fifo_full in;
//                  gnt, wr, wr_data, owner, busy out
//
// Timing: an IDLE cycle is spent choosing the owner, so the first write of a
// burst appears one cycle after the request is seen; back-to-back bursts are
// separated by exactly one IDLE cycle.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Registered state
  state_t            r_state;
  logic [OWN_W-1:0]  r_rr_ptr;
  logic [OWN_W-1:0]  r_owner;
  logic [BC_W-1:0]   r_beat_cnt;

  // Next-state values
  state_t            w_state_nxt;
  logic [OWN_W-1:0]  w_rr_ptr_nxt;
  logic [OWN_W-1:0]  w_owner_nxt;
  logic [BC_W-1:0]   w_beat_cnt_nxt;

  // Datapath / decode
  logic              w_pick_vld;
  logic [OWN_W-1:0]  w_pick_idx;
  logic              w_own_req;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic              w_accept;
  logic [OWN_W-1:0]  w_owner_inc;
  logic [BC_W-1:0]   w_beat_inc;
  logic              w_last_beat;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Round-robin pick: first set request at or above r_rr_ptr, wrapping.
  // Scanning the offsets from highest to lowest lets the smallest offset win.
  always_comb begin
    int               v_idx;
    logic [OWN_W-1:0] v_sel;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    v_idx      = 0;
    v_sel      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      v_sel = OWN_W'(v_idx);
      if (bus.req[v_sel]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = v_sel;
      end
    end
  end

  // Owner's request and word, selected with a compare mux so any NUM_REQ works.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OWN_W'(i)) begin
        w_own_req  = bus.req[i];
        w_own_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_owner_inc = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_beat_inc  = r_beat_cnt + 1'b1;
  assign w_last_beat = (w_beat_inc == BC_W'(MAX_BURST));

  // Accept only in BURST, only for a pending owner word, only with FIFO room.
  // Reset gates the strobe so nothing is written during a reset cycle.
  assign w_accept = rst_n && (r_state == S_BURST) && w_own_req && !bus.fifo_full;

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.fifo_full && w_pick_vld) begin
          w_owner_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_BURST;
        end
      end
      S_BURST: begin
        if (!w_own_req) begin
          // Owner released: leave without taking a word this cycle.
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end else if (w_accept) begin
          w_beat_cnt_nxt = w_beat_inc;
          if (w_last_beat) begin
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = w_owner_inc;
          end
        end
        // Otherwise the FIFO is full: hold everything and retry.
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_gnt     = '0;
    w_wr      = w_accept;
    w_wr_data = '0;
    if (w_accept) begin
      w_gnt[r_owner] = 1'b1;
      w_wr_data      = w_own_data;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.wr      = w_wr;
  assign bus.wr_data = w_wr_data;
  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Requesters: each has a count of words still to deliver and a current word.
  int            pend [N];
  logic [DW-1:0] dat  [N];
  logic          full;

  // Reference model: who owns the port, how many words taken, where the
  // round-robin search starts next, and whether a burst is in progress.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_ptr;

  int          wlog[$];   // owner observed on every DUT write
  logic [63:0] wrbits;    // observed wr history, newest in bit 0

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    r = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      r[i]          = (pend[i] > 0);
      d[i*DW +: DW] = dat[i];
    end
    bus.req       = r;
    bus.req_data  = d;
    bus.fifo_full = full;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then present the requesters' next inputs.
  task automatic step();
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    bit            acc;
    int            o;
    @(negedge clk);
    acc = rst_n && m_busy && (pend[m_owner] > 0) && !full;
    eg  = acc ? (N'(1) << m_owner) : '0;
    ed  = acc ? dat[m_owner] : '0;
    check("gnt",     bus.gnt,     eg);
    check("wr",      bus.wr,      acc);
    check("wr_data", bus.wr_data, ed);
    check("owner",   bus.owner,   m_owner);
    check("busy",    bus.busy,    m_busy);
    check("wr_while_full", bus.wr & full, 0);
    wrbits = {wrbits[62:0], bus.wr};
    if (bus.wr) wlog.push_back(int'(bus.owner));
    o = m_owner;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (!full) begin
        for (int k = 0; k < N; k++) begin
          if (pend[(m_ptr + k) % N] > 0) begin
            m_owner = (m_ptr + k) % N;
            m_beats = 0;
            m_busy  = 1;
            break;
          end
        end
      end
    end else if (pend[m_owner] == 0) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    if (acc) begin
      pend[o]--;
      dat[o] = DW'($urandom);
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    full   = 1'b0;
    wrbits = '0;
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      dat[i]  = DW'($urandom);
    end
    drive();
    step();
    step();
    // Reset state, observed while rst_n is still low
    check("rst_gnt",     bus.gnt,     0);
    check("rst_wr",      bus.wr,      0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_owner",   bus.owner,   0);
    check("rst_busy",    bus.busy,    0);
    rst_n = 1'b1;
    drive();

    // Test 1: requester 1 alone, 6 words -> burst of 4, idle, burst of 2
    pend[1] = 6;
    drive();
    wrbits = '0;
    wlog.delete();
    repeat (10) step();
    check("t1_wr_pattern", wrbits[9:0], 10'b0111101100);
    check("t1_writes", wlog.size(), 6);

    // Test 2: requesters 0 and 2 from reset release
    do_reset();
    pend[0] = 4;
    pend[2] = 4;
    drive();
    wrbits = '0;
    wlog.delete();
    repeat (10) step();
    check("t2_wr_pattern", wrbits[9:0], 10'b0111101111);
    check("t2_writes", wlog.size(), 8);
    for (int k = 0; k < 8 && k < wlog.size(); k++)
      check("t2_owner_seq", wlog[k], (k < 4) ? 0 : 2);
    // Search now starts at 3, so 3 beats 0
    pend[0] = 1;
    pend[3] = 1;
    drive();
    wlog.delete();
    repeat (6) step();
    check("t2_ptr_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t2_ptr_first", wlog[0], 3);
      check("t2_ptr_second", wlog[1], 0);
    end

    // Test 3: FIFO full for 3 cycles after the 2nd accept
    do_reset();
    pend[1] = 4;
    wrbits = '0;
    wlog.delete();
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      drive();
      step();
    end
    full = 1'b0;
    drive();
    check("t3_wr_pattern", wrbits[8:0], 9'b011000110);
    check("t3_writes", wlog.size(), 4);

    // Test 4: requester 3 releases after 2 words while 0 waits
    do_reset();
    pend[3] = 2;
    drive();
    wrbits = '0;
    wlog.delete();
    step();
    pend[0] = 5;
    drive();
    repeat (5) step();
    check("t4_wr_pattern", wrbits[5:0], 6'b011001);
    if (wlog.size() >= 3) begin
      check("t4_own0", wlog[0], 3);
      check("t4_own1", wlog[1], 3);
      check("t4_own2", wlog[2], 0);
    end else begin
      check("t4_writes_early", wlog.size(), 3);
    end
    repeat (8) step();
    check("t4_writes", wlog.size(), 7);

    // Test 5: reset after the 2nd beat of a burst
    do_reset();
    pend[2] = 6;
    drive();
    wlog.delete();
    repeat (3) step();
    check("t5_pre_writes", wlog.size(), 2);
    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    check("t5_post_busy",  bus.busy,  0);
    check("t5_post_owner", bus.owner, 0);
    pend[1] = 2;
    drive();
    wlog.delete();
    repeat (4) step();
    check("t5_restart_writes", wlog.size(), 2);
    if (wlog.size() > 0) check("t5_restart_owner", wlog[0], 1);

    // Test 6: everyone requesting for 40 cycles
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1000;
    drive();
    wrbits = '0;
    wlog.delete();
    repeat (40) step();
    check("t6_writes", wlog.size(), 32);
    for (int k = 0; k < 32 && k < wlog.size(); k++)
      check("t6_owner_seq", wlog[k], (k / MB) % N);
    check("t6_wr_pattern", wrbits[9:0], 10'b0111101111);

    // Random traffic with random back-pressure and occasional resets
    for (int i = 0; i < N; i++) pend[i] = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      full  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++)
        if (pend[i] == 0 && $urandom_range(0, 7) == 0) pend[i] = $urandom_range(1, 9);
      drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
